// File: rtl/bsc_axiu_pkg.sv
// Shared constants and types for the AXI-utility stream blocks.
// Used by bsc_axiu_axis_tid_mux and its round-robin arbiter.
package bsc_axiu_pkg;

    localparam int TID_WIDTH          = 1;
    localparam int DEFAULT_DATA_WIDTH = 64;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/bsc_axiu_rr_arb2.sv
// Two-requester round-robin arbiter; a held lock overrides the rotation.
// last_gnt resets to 1 so requester 0 wins the first tie.
module bsc_axiu_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       lock_id,
    input  logic       advance,
    output logic       sel
);

    logic last_gnt;

    always_comb begin
        sel = req[1];
        if (lock) begin
            sel = lock_id;
        end else if (req[0] && req[1]) begin
            sel = ~last_gnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt <= 1'b1;
        end else if (advance) begin
            last_gnt <= sel;
        end
    end

endmodule

// File: rtl/bsc_axiu_axis_tid_mux.sv
// Merges two AXI-Stream sources into one registered stream tagged with a 1-bit TID.
// Define BSC_AXIU_MUX_PKT_LOCK_EN to keep packets atomic (lock until tlast).
module bsc_axiu_axis_tid_mux
    import bsc_axiu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tlast,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tlast,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [TID_WIDTH-1:0]  m_tid,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    logic                  can_load;
    logic                  sel;
    logic                  accept;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  lock;
    logic                  lock_id;

    assign can_load  = !m_tvalid || m_tready;
    assign s0_tready = can_load && !sel;
    assign s1_tready = can_load && sel;
    assign accept    = can_load && (sel ? s1_tvalid : s0_tvalid);
    assign beat_last = sel ? s1_tlast : s0_tlast;
    assign beat_data = sel ? s1_tdata : s0_tdata;

    bsc_axiu_rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     ({s1_tvalid, s0_tvalid}),
        .lock    (lock),
        .lock_id (lock_id),
        .advance (accept),
        .sel     (sel)
    );

`ifdef BSC_AXIU_MUX_PKT_LOCK_EN
    lock_state_e state, state_next;
    logic        lock_id_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= UNLOCKED;
            lock_id <= 1'b0;
        end else begin
            state   <= state_next;
            lock_id <= lock_id_next;
        end
    end

    // Only the owning source can be accepted while locked, so its tlast ends the packet.
    always_comb begin
        state_next   = state;
        lock_id_next = lock_id;
        case (state)
            UNLOCKED: begin
                if (accept && !beat_last) begin
                    state_next   = LOCKED;
                    lock_id_next = sel;
                end
            end
            LOCKED: begin
                if (accept && beat_last) begin
                    state_next = UNLOCKED;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    assign lock = (state == LOCKED);
`else
    assign lock    = 1'b0;
    assign lock_id = 1'b0;
`endif

    // Payload fields only change on a handshake; a drain without a new beat just clears valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tid    <= '0;
            m_tlast  <= 1'b0;
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= beat_data;
            m_tid    <= sel;
            m_tlast  <= beat_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule
